kernel_sysid_checker: RTL and testbench
=======================================

Name: kernel_sysid_checker

Overview:
- Avalon-MM read master that sequences the two-word system-ID slave: word 0 is the ID and word 1 is the build timestamp.
- On start, reads both words, compares them against expected constants, and reports match or mismatch and timeout status to boot or health logic.
- Sits between the system-ID slave and the kernel's status/CSR block; prevents software from running against a mismatched hardware build.

Parameters:
- EXPECTED_ID, 32'h0000_0001, value required at slave address 0.
- EXPECTED_TS, 32'd1531377617, value required at slave address 1.
- TIMEOUT_CYCLES, 256, cycles allowed from read assertion to readdatavalid (1..65535).
- MAX_RETRIES, 2, extra attempts per word after a timeout (0..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a check sequence.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  sequence in progress.
- done  out  1  level; sequence finished; held until the next accepted start.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- timeout_err  out  1  a word exhausted all of its retries.
- captured_id  out  32  last ID read.
- captured_ts  out  32  last timestamp read.

Behaviour:
- Reset values:
  - All outputs are 0; captured_* are 32'h0.
  - State is IDLE; timeout and retry counters are 0.
- State machine states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- IDLE or FIN with start=1:
  - Next state is ID_REQ.
  - done, id_ok, ts_ok and timeout_err clear.
  - Retry counter clears.
  - busy=1 from the next cycle.
- start during any other state is ignored.
- xx_REQ states:
  - avm_read=1; avm_address = 0 in ID_REQ, 1 in TS_REQ.
  - Address and read stay stable while avm_waitrequest=1.
  - Move to xx_WAIT on the cycle avm_read=1 and avm_waitrequest=0. avm_read is 0 in xx_WAIT.
- Timeout counter:
  - Loads 0 on entering xx_REQ and increments every cycle in xx_REQ and xx_WAIT.
  - Reaching TIMEOUT_CYCLES-1 without accepted data counts as a timeout. This includes an indefinite waitrequest stall; in that case avm_read drops on the timeout cycle.
- xx_WAIT with avm_readdatavalid=1:
  - Capture avm_readdata into captured_id or captured_ts; the ok flag is registered in the same cycle.
  - ID_WAIT goes to TS_REQ; TS_WAIT goes to FIN.
  - Retry counter clears when moving to TS_REQ.
- Timeout with retry count below MAX_RETRIES: increment the retry count and return to the same xx_REQ. A late readdatavalid from the abandoned attempt, arriving in the new xx_WAIT, is accepted as valid for the same word.
- Timeout with retry count equal to MAX_RETRIES:
  - timeout_err=1 and go to FIN.
  - If the ID word timed out, the timestamp word is not read; ts_ok=0.
- MAX_RETRIES=0 means a single attempt.
- FIN: busy=0, done=1; flags hold.
- avm_readdatavalid is ignored in IDLE, FIN and xx_REQ.
- Simultaneous timeout and readdatavalid in the same cycle: data wins, no retry.
- Mismatched data does not trigger a retry; the sequence continues, with the ok flag low.
- Reset mid-sequence: avm_read=0 on the cycle after reset is sampled; return to the reset values.
- Latency with zero waitrequest and readdatavalid one cycle after acceptance:
  - start at cycle 0; ID_REQ at cycles 1–2; TS_REQ at cycles 3–4; done=1 at cycle 5.

Optional Feature:
- Macro: KERNEL_SYSID_AUTOSTART_EN.
- Defined: an internal start pulse fires on the first cycle after reset deasserts, so the check runs once without software. External start still works afterwards.
- Undefined: the block waits for external start only; no extra logic.

Decomposition:
- Package kernel_sysid_pkg holds:
  - the state enum (3 bits);
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - default expected-value constants;
  - the width function for the timeout counter (clog2 of TIMEOUT_CYCLES).
- One sub-module, kernel_sysid_rd_timer: timeout counter with load/enable/expired and a retry counter. The FSM and capture logic stay in the top module.

Test Plan:
- Nominal: slave returns 1 then 1531377617 with no stall and readdatavalid at +1 → done=1 at cycle 5, id_ok=1, ts_ok=1, timeout_err=0.
- Stall: waitrequest held for 7 cycles on each word → avm_address and avm_read stable throughout; done=1 at cycle 19; both ok flags 1.
- Mismatch: ID word returns 32'h2 → captured_id=2, id_ok=0; timestamp still read, ts_ok=1; done=1; no retry issued.
- Timeout: TIMEOUT_CYCLES=16, MAX_RETRIES=2, ID never returns → exactly 3 read attempts; timeout_err=1, id_ok=0, ts_ok=0; no read issued at address 1; done=1 after 48 cycles in REQ/WAIT.
- Late reply: first ID attempt times out, old response arrives 3 cycles into the retry → accepted; sequence completes with id_ok=1.
- Reset and start abuse: reset asserted in TS_WAIT → next cycle avm_read=0 and all outputs 0. start pulsed while busy → ignored. start pulsed in FIN → flags clear and a new sequence runs.

Source files
------------

// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// slave word addresses, default expected values and the timeout counter width helper.
package kernel_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam logic        SYSID_ADDR_ID          = 1'b0;
  localparam logic        SYSID_ADDR_TS          = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1531377617;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int          DEFAULT_MAX_RETRIES    = 2;
  localparam int          RETRY_W                = 4;

  // clog2(cycles), never less than 1; cycles is limited to 16 bits
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 17; i++) begin
      if ((32'sd1 << i) < cycles) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/kernel_sysid_rd_timer.sv
// Per-attempt timeout counter (load/enable/expired) and per-word retry counter
// for the system-ID read sequencer.
module kernel_sysid_rd_timer
  import kernel_sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               enable,
  input  logic               retry_clr,
  input  logic               retry_inc,
  output logic               expired,
  output logic               expire_next,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int             CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  // next-value logic for the timeout and retry counters
  always_comb begin
    if (load) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (retry_clr) begin
      retry_d = {RETRY_W{1'b0}};
    end else if (retry_inc) begin
      retry_d = retry_q + RETRY_W'(1);
    end else begin
      retry_d = retry_q;
    end
  end

  // counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      retry_q <= {RETRY_W{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // expire_next lets the owner drop its read strobe on the timeout cycle itself
  assign expired     = (cnt_q == CNT_LAST);
  assign expire_next = (cnt_d == CNT_LAST);
  assign retry_cnt   = retry_q;

endmodule

// File: rtl/kernel_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and build timestamp words and
// flags match/mismatch/timeout. Optional macro KERNEL_SYSID_AUTOSTART_EN runs one check after reset.
module kernel_sysid_checker
  import kernel_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_address_q, avm_address_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               id_ok_q, id_ok_d;
  logic               ts_ok_q, ts_ok_d;
  logic               timeout_err_q, timeout_err_d;
  logic [31:0]        captured_id_q, captured_id_d;
  logic [31:0]        captured_ts_q, captured_ts_d;

  logic               start_s;
  logic               accepted_s;
  logic               attempt_tmo_s;
  logic               word_is_id_s;
  logic               tmr_load_s;
  logic               tmr_enable_s;
  logic               retry_clr_s;
  logic               retry_inc_s;
  logic               tmr_expired_s;
  logic               tmr_expire_next_s;
  logic [RETRY_W-1:0] retry_cnt_s;

`ifdef KERNEL_SYSID_AUTOSTART_EN
  logic auto_q, auto_d;

  assign auto_d = 1'b0;

  // armed during reset, fires once on the first cycle after reset releases
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= auto_d;
    end
  end

  assign start_s = start | auto_q;
`else
  assign start_s = start;
`endif

  assign accepted_s   = avm_read_q & ~avm_waitrequest;
  assign word_is_id_s = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT);
  assign tmr_enable_s = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT) ||
                        (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);

  kernel_sysid_rd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clock       (clock),
    .reset       (reset),
    .load        (tmr_load_s),
    .enable      (tmr_enable_s),
    .retry_clr   (retry_clr_s),
    .retry_inc   (retry_inc_s),
    .expired     (tmr_expired_s),
    .expire_next (tmr_expire_next_s),
    .retry_cnt   (retry_cnt_s)
  );

  // sequencer next-state, capture and flag logic
  always_comb begin
    state_d       = state_q;
    tmr_load_s    = 1'b0;
    retry_clr_s   = 1'b0;
    retry_inc_s   = 1'b0;
    attempt_tmo_s = 1'b0;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_err_d = timeout_err_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_s) begin
          state_d       = ST_ID_REQ;
          tmr_load_s    = 1'b1;
          retry_clr_s   = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ID_REQ, ST_TS_REQ: begin
        if (tmr_expired_s) begin
          attempt_tmo_s = 1'b1;
        end else if (accepted_s) begin
          state_d = (state_q == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_ID_WAIT: begin
        // data beats a coincident timeout; a mismatch still moves on
        if (avm_readdatavalid) begin
          captured_id_d = avm_readdata;
          id_ok_d       = (avm_readdata == EXPECTED_ID);
          state_d       = ST_TS_REQ;
          tmr_load_s    = 1'b1;
          retry_clr_s   = 1'b1;
        end else if (tmr_expired_s) begin
          attempt_tmo_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          captured_ts_d = avm_readdata;
          ts_ok_d       = (avm_readdata == EXPECTED_TS);
          state_d       = ST_FIN;
        end else if (tmr_expired_s) begin
          attempt_tmo_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (attempt_tmo_s) begin
      if (retry_cnt_s < RETRY_MAX) begin
        retry_inc_s = 1'b1;
        tmr_load_s  = 1'b1;
        state_d     = word_is_id_s ? ST_ID_REQ : ST_TS_REQ;
      end else begin
        timeout_err_d = 1'b1;
        state_d       = ST_FIN;
      end
    end else begin
      timeout_err_d = timeout_err_d;
    end
  end

  // registered bus and status outputs follow the upcoming state
  always_comb begin
    busy_d     = (state_d == ST_ID_REQ) || (state_d == ST_ID_WAIT) ||
                 (state_d == ST_TS_REQ) || (state_d == ST_TS_WAIT);
    done_d     = (state_d == ST_FIN);
    avm_read_d = ((state_d == ST_ID_REQ) || (state_d == ST_TS_REQ)) && !tmr_expire_next_s;
    if (state_d == ST_TS_REQ) begin
      avm_address_d = SYSID_ADDR_TS;
    end else if (state_d == ST_ID_REQ) begin
      avm_address_d = SYSID_ADDR_ID;
    end else begin
      avm_address_d = avm_address_q;
    end
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      captured_id_q <= 32'h0000_0000;
      captured_ts_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_err_q <= timeout_err_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_err_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Scoreboard bench for kernel_sysid_checker: a behavioural system-ID slave with
// configurable stall, dropped and late responses; expected outcomes queued at start.
module tb_kernel_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0001;
  localparam logic [31:0] EXP_TS = 32'd1531377617;
  localparam int          TMO    = 16;
  localparam int          MR     = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] captured_id, captured_ts;

  kernel_sysid_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (MR)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout_err      (timeout_err),
    .captured_id      (captured_id),
    .captured_ts      (captured_ts)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // slave configuration and observation
  int          cfg_stall = 0;
  logic [31:0] cfg_id_data = EXP_ID;
  logic [31:0] cfg_ts_data = EXP_TS;
  int          cfg_drop_id = 0;
  int          cfg_late = 0;
  int          acc0 = 0, acc1 = 0, stall_viol = 0;

  typedef struct {
    int          cyc;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] cid;
    logic [31:0] cts;
    int          a0;
    int          a1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_cid = 32'h0;
  logic [31:0] model_cts = 32'h0;

  // behavioural slave: inputs are updated on the falling edge
  initial begin
    int          wait_left, pend_delay;
    logic [31:0] pend_data, data;
    logic        prev_read, prev_wr, prev_addr;
    wait_left = 0; pend_delay = 0; pend_data = 32'h0;
    prev_read = 1'b0; prev_wr = 1'b0; prev_addr = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    forever begin
      @(negedge clock);
      if (prev_read && prev_wr && (!avm_read || (avm_address != prev_addr))) stall_viol++;
      avm_readdatavalid = 1'b0;
      if (pend_delay > 0) begin
        pend_delay--;
        if (pend_delay == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (avm_read) begin
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          data = avm_address ? cfg_ts_data : cfg_id_data;
          if (avm_address) acc1++; else acc0++;
          if (!avm_address && (cfg_drop_id > 0)) begin
            cfg_drop_id--;
            if (cfg_late > 0) begin
              pend_delay = cfg_late;
              pend_data  = data;
              cfg_late   = 0;
            end
          end else begin
            pend_delay = 1;
            pend_data  = data;
          end
          wait_left = cfg_stall;
        end
      end else begin
        avm_waitrequest = 1'b0;
        wait_left       = cfg_stall;
      end
      prev_read = avm_read;
      prev_wr   = avm_waitrequest;
      prev_addr = avm_address;
    end
  end

  // one check sequence: push expectation, start, wait for done, pop and compare
  task automatic run_seq(input string tag, input int stall, input logic [31:0] idv,
                         input logic [31:0] tsv, input int drop, input int late,
                         input int exp_cyc, input int exp_a0, input bit abuse);
    exp_t e, g;
    int   c0;
    cfg_stall = stall; cfg_id_data = idv; cfg_ts_data = tsv;
    cfg_drop_id = drop; cfg_late = late;
    acc0 = 0; acc1 = 0; stall_viol = 0;
    e.tmo   = (drop > MR) && (late == 0);
    e.id_ok = !e.tmo && (idv == EXP_ID);
    e.ts_ok = !e.tmo && (tsv == EXP_TS);
    if (!e.tmo) begin
      model_cid = idv;
      model_cts = tsv;
    end
    e.cid = model_cid; e.cts = model_cts;
    e.cyc = exp_cyc; e.a0 = exp_a0; e.a1 = e.tmo ? 0 : 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1; c0 = cyc;
    @(negedge clock);
    start = 1'b0;
    check_eq({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_done1"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_flags1"}, {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
    while (!done && ((cyc - c0) < 200)) begin
      start = abuse && ((cyc - c0) == 3);
      @(negedge clock);
    end
    start = 1'b0;
    g = sb.pop_front();
    check_eq({tag, "_done_cyc"}, cyc - c0, g.cyc);
    check_eq({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_id_ok"}, {31'd0, id_ok}, {31'd0, g.id_ok});
    check_eq({tag, "_ts_ok"}, {31'd0, ts_ok}, {31'd0, g.ts_ok});
    check_eq({tag, "_tmo"}, {31'd0, timeout_err}, {31'd0, g.tmo});
    check_eq({tag, "_cap_id"}, captured_id, g.cid);
    check_eq({tag, "_cap_ts"}, captured_ts, g.cts);
    check_eq({tag, "_acc0"}, acc0, g.a0);
    check_eq({tag, "_acc1"}, acc1, g.a1);
    check_eq({tag, "_stall_stable"}, stall_viol, 32'd0);
    @(negedge clock);
    check_eq({tag, "_done_hold"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_flags"}, {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
    check_eq({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
    check_eq({tag, "_cap_id"}, captured_id, 32'h0);
    check_eq({tag, "_cap_ts"}, captured_ts, 32'h0);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_all_zero("rst");

    run_seq("nominal",   0, EXP_ID,        EXP_TS,        0, 0,  5,          1, 1'b0);
    run_seq("stall",     7, EXP_ID,        EXP_TS,        0, 0,  19,         1, 1'b0);
    run_seq("mism_id",   0, 32'h2,         EXP_TS,        0, 0,  5,          1, 1'b0);
    run_seq("mism_ts",   0, EXP_ID,        32'hdeadbeef,  0, 0,  5,          1, 1'b0);
    run_seq("busy_start",0, EXP_ID,        EXP_TS,        0, 0,  5,          1, 1'b1);
    run_seq("timeout",   0, EXP_ID,        EXP_TS,        3, 0,  3 * TMO + 1, 3, 1'b0);
    run_seq("fin_start", 0, EXP_ID,        EXP_TS,        0, 0,  5,          1, 1'b0);
    // first ID reply lands 3 cycles into the retry (retry REQ at cycle TMO+1)
    run_seq("late",      0, EXP_ID,        EXP_TS,        2, TMO + 3, TMO + 7, 2, 1'b0);

    // reset while the timestamp read is outstanding
    cfg_stall = 0; cfg_id_data = EXP_ID; cfg_ts_data = EXP_TS; cfg_drop_id = 0; cfg_late = 0;
    @(negedge clock);
    start = 1'b1; c0 = cyc;
    @(negedge clock);
    start = 1'b0;
    while ((cyc - c0) < 4) @(negedge clock);
    check_eq("tswait_busy", {31'd0, busy}, 32'd1);
    check_eq("tswait_id_ok", {31'd0, id_ok}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("midrst");
    reset = 1'b0;
    model_cid = 32'h0; model_cts = 32'h0;
    repeat (3) @(negedge clock);
    check_eq("post_rst_idle", {30'd0, busy, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
